// File: rtl/fp_mul_round_pack_if.sv
// Result back-end bus: multiply-stage beat in, packed binary32 plus flags out.
// master = producer/consumer side (bench or neighbours), slave = the back-end itself.
interface fp_mul_round_pack_if;
  logic [1:0]  rm;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_mant;
  logic        in_nan;
  logic        in_inf;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;
  logic        inf;
  logic        nan;

  modport master (
    output rm, in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact, inf, nan
  );

  modport slave (
    input  rm, in_valid, in_sign, in_exp, in_mant, in_nan, in_inf, in_zero, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact, inf, nan
  );
endinterface

// File: rtl/fp_mul_round_pack.sv
// Normalize/round/pack of a 48-bit significand product to binary32; FP_MUL_SUBNORMAL_EN selects gradual underflow (else flush-to-zero).
// Latency 2 cycles (stage A normalize, stage B round/pack), 1 beat/cycle throughput, 2 beats of storage.
// Stage B holds while out_valid & ~out_ready; in_ready = ~A_valid | ~out_valid | out_ready (combinational from out_ready).
module fp_mul_round_pack #(
  parameter int EXP_WIDTH      = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_mul_round_pack_if.slave bus
);

  localparam int EXP_MAX = (1 << EXP_WIDTH) - 1;

  // ---------------- stage A: normalize ----------------
  logic               norm;
  logic [23:0]        sig_n;
  logic               g_n, r_n, s_n;
  logic signed [10:0] exp_n;
  logic               tiny_n;
  logic [23:0]        sig_d;
  logic               g_d, r_d, s_d;
`ifdef FP_MUL_SUBNORMAL_EN
  logic signed [10:0] sh_full;
  logic [4:0]         sh;
  logic [51:0]        shv;
`endif

  always_comb begin
    norm = bus.in_mant[47];
    if (norm) begin
      sig_n = bus.in_mant[47:24];
      g_n   = bus.in_mant[23];
      r_n   = bus.in_mant[22];
      s_n   = |bus.in_mant[21:0];
    end else begin
      sig_n = bus.in_mant[46:23];
      g_n   = bus.in_mant[22];
      r_n   = bus.in_mant[21];
      s_n   = |bus.in_mant[20:0];
    end
    exp_n  = {bus.in_exp[9], bus.in_exp} + {10'd0, norm};
    tiny_n = (exp_n <= 11'sd0);
    sig_d  = sig_n;
    g_d    = g_n;
    r_d    = r_n;
    s_d    = s_n;
`ifdef FP_MUL_SUBNORMAL_EN
    // Denormalize by 1 - exp; beyond 26 every significand bit already lands in sticky.
    sh_full = 11'sd1 - exp_n;
    sh      = (sh_full > 11'sd26) ? 5'd26 : sh_full[4:0];
    shv     = {sig_n, g_n, r_n, 26'd0} >> sh;
    if (tiny_n) begin
      sig_d = shv[51:28];
      g_d   = shv[27];
      r_d   = shv[26];
      s_d   = s_n | (|shv[25:0]);
    end
`endif
  end

  logic               a_vld_q;
  logic               a_sign_q, a_g_q, a_r_q, a_s_q, a_tiny_q;
  logic               a_nan_q, a_inf_q, a_zero_q;
  logic [1:0]         a_rm_q;
  logic [23:0]        a_sig_q;
  logic signed [10:0] a_exp_q;
  logic               b_vld_q;
  logic               b_adv;
  logic               in_rdy;

  assign b_adv  = ~b_vld_q | bus.out_ready;
  assign in_rdy = ~a_vld_q | b_adv;
  assign bus.in_ready = in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q  <= 1'b0;
      a_sign_q <= 1'b0;
      a_g_q    <= 1'b0;
      a_r_q    <= 1'b0;
      a_s_q    <= 1'b0;
      a_tiny_q <= 1'b0;
      a_nan_q  <= 1'b0;
      a_inf_q  <= 1'b0;
      a_zero_q <= 1'b0;
      a_rm_q   <= 2'd0;
      a_sig_q  <= 24'd0;
      a_exp_q  <= 11'sd0;
    end else begin
      if (in_rdy) a_vld_q <= bus.in_valid;
      if (in_rdy && bus.in_valid) begin
        a_sign_q <= bus.in_sign;
        a_g_q    <= g_d;
        a_r_q    <= r_d;
        a_s_q    <= s_d;
        a_tiny_q <= tiny_n;
        a_nan_q  <= bus.in_nan;
        a_inf_q  <= bus.in_inf;
        a_zero_q <= bus.in_zero | (bus.in_mant == 48'd0);
        a_rm_q   <= bus.rm;
        a_sig_q  <= sig_d;
        a_exp_q  <= exp_n;
      end
    end
  end

  // ---------------- stage B: round and pack ----------------
  logic               inc, inx, away, carry;
  logic [24:0]        sum;
  logic [23:0]        sig_r;
  logic signed [10:0] exp_r;
  logic [31:0]        res_d;
  logic               ovf_d, unf_d, inx_d, inf_d, nan_d;

  always_comb begin
    inx = a_g_q | a_r_q | a_s_q;
    case (a_rm_q)
      2'd0:    inc = a_g_q & (a_r_q | a_s_q | a_sig_q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = inx & ~a_sign_q;
      default: inc = inx & a_sign_q;
    endcase
    away  = (a_rm_q == 2'd0) | ((a_rm_q == 2'd2) & ~a_sign_q) | ((a_rm_q == 2'd3) & a_sign_q);
    sum   = {1'b0, a_sig_q} + {24'd0, inc};
    carry = sum[24];
    sig_r = carry ? 24'h800000 : sum[23:0];
    exp_r = a_exp_q + {10'd0, carry};

    res_d = 32'd0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    inf_d = 1'b0;
    nan_d = 1'b0;
    if (a_nan_q) begin
      res_d = 32'h7FC00000;
      nan_d = 1'b1;
    end else if (a_inf_q) begin
      res_d = {a_sign_q, 8'hFF, 23'd0};
      inf_d = 1'b1;
    end else if (a_zero_q) begin
      res_d = {a_sign_q, 31'd0};
    end else if (a_tiny_q) begin
`ifdef FP_MUL_SUBNORMAL_EN
      // A carry into bit 23 is exactly the step up to the smallest normal.
      res_d = {a_sign_q, 7'd0, sig_r[23], sig_r[MANTISSA_WIDTH-1:0]};
      inx_d = inx;
      unf_d = inx;
`else
      res_d = {a_sign_q, 31'd0};
      inx_d = 1'b1;
      unf_d = 1'b1;
`endif
    end else if (exp_r >= 11'(EXP_MAX)) begin
      ovf_d = 1'b1;
      inx_d = 1'b1;
      inf_d = away;
      res_d = away ? {a_sign_q, 8'hFF, 23'd0} : {a_sign_q, 31'h7F7FFFFF};
    end else begin
      res_d = {a_sign_q, exp_r[EXP_WIDTH-1:0], sig_r[MANTISSA_WIDTH-1:0]};
      inx_d = inx;
    end
  end

  logic [31:0] res_q;
  logic        ovf_q, unf_q, inx_q, inf_q, nan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_vld_q <= 1'b0;
      res_q   <= 32'd0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
    end else if (b_adv) begin
      b_vld_q <= a_vld_q;
      if (a_vld_q) begin
        res_q <= res_d;
        ovf_q <= ovf_d;
        unf_q <= unf_d;
        inx_q <= inx_d;
        inf_q <= inf_d;
        nan_q <= nan_d;
      end
    end
  end

  assign bus.out_valid = b_vld_q;
  assign bus.result    = res_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.inexact   = inx_q;
  assign bus.inf       = inf_q;
  assign bus.nan       = nan_q;

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Bench for fp_mul_round_pack: directed vectors plus random beats scored against a value-level rounding model.
module tb_fp_mul_round_pack;

  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [47:0] mant;
    logic [1:0]  rm;
    logic        nan;
    logic        inf;
    logic        zero;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_mul_round_pack_if bus();

  fp_mul_round_pack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int chk_cnt   = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int delivered = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [4:0] flg();
    return {bus.overflow, bus.underflow, bus.inexact, bus.inf, bus.nan};
  endfunction

  // Reference: treat the product as an exact integer and round it to the ulp of
  // the target binade by remainder-vs-half comparison.
  function automatic logic [36:0] model(input beat_t b);
    logic [127:0] p, kept, rem, half;
    int lead, bexp, drop, e_eff;
    logic tiny, inx, inc, away;
    longint mag;
    if (b.nan)  return {32'h7FC00000, 5'b00001};
    if (b.inf)  return {b.sign, 8'hFF, 23'd0, 5'b00010};
    if (b.zero || b.mant == 48'd0) return {b.sign, 31'd0, 5'b00000};
    lead = 0;
    for (int i = 0; i < 48; i++) if (b.mant[i]) lead = i;
    bexp = int'($signed(b.exp)) + lead - 46;
    tiny = (bexp <= 0);
`ifndef FP_MUL_SUBNORMAL_EN
    if (tiny) return {b.sign, 31'd0, 5'b01100};
`endif
    drop = lead - 23 + (tiny ? 1 - bexp : 0);
    if (drop > 100) drop = 100;  // the whole product is already below half an ulp
    p    = 128'(b.mant);
    kept = p >> drop;
    rem  = p - (kept << drop);
    half = 128'd1 << (drop - 1);
    inx  = (rem != 0);
    case (b.rm)
      2'd0:    inc = (rem > half) || ((rem == half) && kept[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = inx && !b.sign;
      default: inc = inx && b.sign;
    endcase
    e_eff = tiny ? 1 : bexp;
    mag = (longint'(e_eff) - 1) * (longint'(1) << 23) + longint'(kept[63:0]) + (inc ? 64'd1 : 64'd0);
    if (mag >= 64'h7F800000) begin
      away = (b.rm == 2'd0) || ((b.rm == 2'd2) && !b.sign) || ((b.rm == 2'd3) && b.sign);
      return away ? {b.sign, 8'hFF, 23'd0, 5'b10110} : {b.sign, 31'h7F7FFFFF, 5'b10100};
    end
    return {b.sign, mag[30:0], 1'b0, tiny && inx, inx, 2'b00};
  endfunction

  function automatic beat_t mk(input logic s, input logic [9:0] e, input logic [47:0] m,
                               input logic [1:0] r, input logic n, input logic i, input logic z);
    beat_t b;
    b.sign = s; b.exp = e; b.mant = m; b.rm = r; b.nan = n; b.inf = i; b.zero = z;
    return b;
  endfunction

  function automatic beat_t bus_beat();
    return mk(bus.in_sign, bus.in_exp, bus.in_mant, bus.rm, bus.in_nan, bus.in_inf, bus.in_zero);
  endfunction

  task automatic rand_beat(output beat_t b);
    logic [23:0] x, y;
    int sel;
    x = {1'b1, 23'($urandom)};
    y = {1'b1, 23'($urandom)};
    b.mant = 48'(x) * 48'(y);
    sel = $urandom_range(0, 11);
    if (sel == 0) b.mant[22:0] = 23'd0;
    if (sel == 1) b.mant[21:0] = 22'd0;
    sel = $urandom_range(0, 9);
    if (sel < 2)       b.exp = 10'($urandom_range(0, 40)) - 10'd30;
    else if (sel == 2) b.exp = 10'($urandom_range(240, 270));
    else               b.exp = 10'($urandom_range(60, 190));
    b.sign = 1'($urandom);
    b.rm   = 2'($urandom);
    b.nan  = ($urandom_range(0, 19) == 0);
    b.inf  = ($urandom_range(0, 19) == 0);
    b.zero = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 29) == 0) b.mant = 48'd0;
  endtask

  // Scoreboard: expectation queued on accept, compared on drain.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_beat", {bus.result, flg()}, 37'd0 - 1);
        else begin
          mon_e = exp_q.pop_front();
          check("beat", {bus.result, flg()}, mon_e);
          delivered++;
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model(bus_beat()));
    end
  end

  task automatic drive(input beat_t b);
    bus.in_sign  = b.sign;
    bus.in_exp   = b.exp;
    bus.in_mant  = b.mant;
    bus.rm       = b.rm;
    bus.in_nan   = b.nan;
    bus.in_inf   = b.inf;
    bus.in_zero  = b.zero;
    bus.in_valid = 1'b1;
  endtask

  // Leaves in_valid high at posedge+1 after the accepting edge.
  task automatic send(input beat_t b, input bit rnd);
    bit acc;
    acc = 1'b0;
    drive(b);
    for (int i = 0; i < 100 && !acc; i++) begin
      if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input beat_t b, input logic [31:0] er, input logic [4:0] ef);
    send(b, 1'b0);
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_res"}, 64'(bus.result), 64'(er));
    check({tag, "_flg"}, 64'(flg()), 64'(ef));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  beat_t bp[4];
  beat_t rb;
  int    idx, base, n;
  bit    acc_now;

  initial begin
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = 10'd0; bus.in_mant = 48'd0;
    bus.rm = 2'd0; bus.in_nan = 1'b0; bus.in_inf = 1'b0; bus.in_zero = 1'b0;
    bus.out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_result",    64'({bus.result, flg()}), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);

    dir("mul_1p5", mk(0, 10'd127, 48'h900000000000, 2'd0, 0, 0, 0), 32'h40100000, 5'b00000);
    dir("tie_rne", mk(0, 10'd127, 48'h400000400000, 2'd0, 0, 0, 0), 32'h3F800000, 5'b00100);
    dir("tie_pinf", mk(0, 10'd127, 48'h400000400000, 2'd2, 0, 0, 0), 32'h3F800001, 5'b00100);
    dir("tie_minf", mk(0, 10'd127, 48'h400000400000, 2'd3, 0, 0, 0), 32'h3F800000, 5'b00100);
    dir("ovf_rne", mk(0, 10'd254, 48'h800000000000, 2'd0, 0, 0, 0), 32'h7F800000, 5'b10110);
    dir("ovf_rtz", mk(0, 10'd254, 48'h800000000000, 2'd1, 0, 0, 0), 32'h7F7FFFFF, 5'b10100);
`ifdef FP_MUL_SUBNORMAL_EN
    dir("unf", mk(0, 10'd0, 48'h400000000000, 2'd0, 0, 0, 0), 32'h00400000, 5'b00000);
`else
    dir("unf", mk(0, 10'd0, 48'h400000000000, 2'd0, 0, 0, 0), 32'h00000000, 5'b01100);
`endif
    dir("sp_nan",  mk(0, 10'd127, 48'h900000000000, 2'd0, 1, 1, 1), 32'h7FC00000, 5'b00001);
    dir("sp_inf",  mk(1, 10'd127, 48'h900000000000, 2'd0, 0, 1, 1), 32'hFF800000, 5'b00010);
    dir("sp_zero", mk(0, 10'd127, 48'h900000000000, 2'd0, 0, 0, 1), 32'h00000000, 5'b00000);

    // Backpressure: four back-to-back beats against a stalled sink.
    for (int k = 0; k < 4; k++) begin
      rand_beat(rb);
      bp[k] = rb;
    end
    base = delivered;
    idx  = 0;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 4) drive(bp[idx]);
      @(negedge clk);
      if (c >= 2) begin
        check("bp_in_ready",  64'(bus.in_ready), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_hold",      64'({bus.result, flg()}), 64'(model(bp[0])));
      end
      acc_now = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc_now) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd2);
    bus.out_ready = 1'b1;
    while (idx < 4) begin
      send(bp[idx], 1'b0);
      idx++;
    end
    idle(4);
    check("bp_delivered", 64'(delivered - base), 64'd4);

    // Random traffic with random sink stalls and source gaps.
    for (int k = 0; k < 300; k++) begin
      rand_beat(rb);
      send(rb, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid  = 1'b0;
        bus.out_ready = ($urandom_range(0, 1) != 0);
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream with both stages full.
    bus.out_ready = 1'b0;
    rand_beat(rb);
    send(rb, 1'b0);
    rand_beat(rb);
    send(rb, 1'b0);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_result",    64'({bus.result, flg()}), 64'd0);
    check("mid_rst_in_ready",  64'(bus.in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) n++;
    end
    @(posedge clk);
    #1;
    check("no_stale_beat", 64'(n), 64'd0);
    dir("post_rst", mk(1, 10'd127, 48'h900000000000, 2'd1, 0, 0, 0), 32'hC0100000, 5'b00000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
